// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types and constants for the LEGv8 register-file writeback controller.
package reg_writeback_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 64;
  localparam int NUM_REGS  = 32;
  localparam int XZR_IDX   = 31;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Handshake/write bus of reg_writeback_ctrl; WB_BYPASS_EN adds the two query ports.
interface reg_writeback_ctrl_if;
  import reg_writeback_ctrl_pkg::*;

  logic                 ALU_VALID;
  logic                 ALU_READY;
  logic [REG_IDX_W-1:0] ALU_REG;
  logic [DATA_W-1:0]    ALU_DATA;
  logic                 MEM_VALID;
  logic                 MEM_READY;
  logic [REG_IDX_W-1:0] MEM_REG;
  logic [DATA_W-1:0]    MEM_DATA;
  logic [REG_IDX_W-1:0] WRITE_REG;
  logic [DATA_W-1:0]    WRITE_DATA;
  logic                 REG_WRITE_ENABLE;
  logic [NUM_REGS-1:0]  PENDING_MASK;
  logic                 FULL;
`ifdef WB_BYPASS_EN
  logic [REG_IDX_W-1:0] QUERY_A_REG;
  logic [REG_IDX_W-1:0] QUERY_B_REG;
  logic                 QUERY_A_HIT;
  logic                 QUERY_B_HIT;
  logic [DATA_W-1:0]    QUERY_A_DATA;
  logic [DATA_W-1:0]    QUERY_B_DATA;

  modport master (
    output ALU_VALID, ALU_REG, ALU_DATA, MEM_VALID, MEM_REG, MEM_DATA,
    output QUERY_A_REG, QUERY_B_REG,
    input  ALU_READY, MEM_READY, WRITE_REG, WRITE_DATA, REG_WRITE_ENABLE,
    input  PENDING_MASK, FULL,
    input  QUERY_A_HIT, QUERY_B_HIT, QUERY_A_DATA, QUERY_B_DATA
  );

  modport slave (
    input  ALU_VALID, ALU_REG, ALU_DATA, MEM_VALID, MEM_REG, MEM_DATA,
    input  QUERY_A_REG, QUERY_B_REG,
    output ALU_READY, MEM_READY, WRITE_REG, WRITE_DATA, REG_WRITE_ENABLE,
    output PENDING_MASK, FULL,
    output QUERY_A_HIT, QUERY_B_HIT, QUERY_A_DATA, QUERY_B_DATA
  );
`else
  modport master (
    output ALU_VALID, ALU_REG, ALU_DATA, MEM_VALID, MEM_REG, MEM_DATA,
    input  ALU_READY, MEM_READY, WRITE_REG, WRITE_DATA, REG_WRITE_ENABLE,
    input  PENDING_MASK, FULL
  );

  modport slave (
    input  ALU_VALID, ALU_REG, ALU_DATA, MEM_VALID, MEM_REG, MEM_DATA,
    output ALU_READY, MEM_READY, WRITE_REG, WRITE_DATA, REG_WRITE_ENABLE,
    output PENDING_MASK, FULL
  );
`endif

endinterface

// File: rtl/reg_writeback_ctrl_fifo.sv
// In-order two-push/one-pop FIFO; entries are exposed oldest-first (index 0 = head).
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push0,
  input  wb_entry_t        i_push0_entry,
  input  logic             i_push1,
  input  wb_entry_t        i_push1_entry,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output wb_entry_t        o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_slot1;

  // Second push lands behind the first when both are present.
  assign w_slot1 = r_wptr + PTR_W'(i_push0);

  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[r_wptr] <= i_push0_entry;
    if (i_push1) r_mem[w_slot1] <= i_push1_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_rptr  <= r_rptr + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_entries[k] = r_mem[PTR_W'(r_rptr + PTR_W'(k))];
      o_valid[k]   = CNT_W'(k) < r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// LEGv8 register-file writeback controller: ALU/MEM handshakes, in-order FIFO,
// one write per cycle, pending-write mask. WB_BYPASS_EN adds youngest-write lookup ports.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  reg_writeback_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("reg_writeback_ctrl: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]     w_count;
  wb_entry_t            w_entries [DEPTH];
  logic [DEPTH-1:0]     w_valid;
  logic                 w_alu_enq;
  logic                 w_mem_enq;
  logic                 w_pop;
  wb_entry_t            w_alu_entry;
  wb_entry_t            w_mem_entry;
  logic [NUM_REGS-1:0]  w_mask_next;

  logic [REG_IDX_W-1:0] r_wr_reg;
  logic [DATA_W-1:0]    r_wr_data;
  logic                 r_wr_en;
  logic [NUM_REGS-1:0]  r_pending;

  // Readiness depends only on the registered count, never on VALID.
  assign bus.ALU_READY = (w_count != CNT_W'(DEPTH));
  assign bus.MEM_READY = (w_count <= CNT_W'(DEPTH - 2));
  assign bus.FULL      = (w_count == CNT_W'(DEPTH));

  assign w_alu_enq   = bus.ALU_VALID && bus.ALU_READY && (bus.ALU_REG != ZERO_IDX);
  assign w_mem_enq   = bus.MEM_VALID && bus.MEM_READY && (bus.MEM_REG != ZERO_IDX);
  assign w_alu_entry = '{idx: bus.ALU_REG, data: bus.ALU_DATA};
  assign w_mem_entry = '{idx: bus.MEM_REG, data: bus.MEM_DATA};
  assign w_pop       = (w_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk         (CLK),
    .i_rst_n       (RST_N),
    .i_push0       (w_alu_enq),
    .i_push0_entry (w_alu_entry),
    .i_push1       (w_mem_enq),
    .i_push1_entry (w_mem_entry),
    .i_pop         (w_pop),
    .o_count       (w_count),
    .o_entries     (w_entries),
    .o_valid       (w_valid)
  );

  // Next mask: every entry now in the FIFO is either still queued or moves to the
  // output stage next cycle; the entry now on the outputs commits at this edge.
  always_comb begin
    w_mask_next = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_valid[k]) w_mask_next = w_mask_next | reg_onehot(w_entries[k].idx);
    end
    if (w_alu_enq) w_mask_next = w_mask_next | reg_onehot(bus.ALU_REG);
    if (w_mem_enq) w_mask_next = w_mask_next | reg_onehot(bus.MEM_REG);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_pending <= '0;
    end else begin
      r_pending <= w_mask_next;
      r_wr_en   <= w_pop;
      if (w_pop) begin
        r_wr_reg  <= w_entries[0].idx;
        r_wr_data <= w_entries[0].data;
      end
    end
  end

  assign bus.WRITE_REG        = r_wr_reg;
  assign bus.WRITE_DATA       = r_wr_data;
  assign bus.REG_WRITE_ENABLE = r_wr_en;
  assign bus.PENDING_MASK     = r_pending;

`ifdef WB_BYPASS_EN
  logic [REG_IDX_W-1:0] w_q_reg  [2];
  logic                 w_q_hit  [2];
  logic [DATA_W-1:0]    w_q_data [2];

  assign w_q_reg[0] = bus.QUERY_A_REG;
  assign w_q_reg[1] = bus.QUERY_B_REG;

  // Output stage is the oldest pending write; FIFO entries scanned oldest-first so
  // the youngest match is the one left standing.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_q_hit[p]  = r_wr_en && (r_wr_reg == w_q_reg[p]);
      w_q_data[p] = r_wr_data;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_valid[k] && (w_entries[k].idx == w_q_reg[p])) begin
          w_q_hit[p]  = 1'b1;
          w_q_data[p] = w_entries[k].data;
        end
      end
      if (w_q_reg[p] == ZERO_IDX) w_q_hit[p] = 1'b0;
    end
  end

  assign bus.QUERY_A_HIT  = w_q_hit[0];
  assign bus.QUERY_A_DATA = w_q_data[0];
  assign bus.QUERY_B_HIT  = w_q_hit[1];
  assign bus.QUERY_B_DATA = w_q_data[1];
`endif

endmodule
